// File: rtl/oc8051_fetch_queue.sv
// Instruction-byte prefetch queue for the 8051 core: streams code ROM bytes into a
// circular buffer and presents a four-byte window at the current code address.
module oc8051_fetch_queue #(
    parameter int QDEPTH   = 8,
    parameter int ROM_SIZE = 10000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] cxrom_addr,
    input  logic [31:0] cxrom_data_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [1:0]  consume,
    output logic [31:0] win_data,
    output logic [2:0]  win_cnt,
    output logic [15:0] win_pc,
    output logic        err
);

    localparam int PW = $clog2(QDEPTH);
    localparam int LW = PW + 1;
    localparam logic [16:0] ROM_LIM = 17'(ROM_SIZE);

    logic [15:0]   fetch_ptr_q, fetch_ptr_d;
    logic [15:0]   win_pc_q, win_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          err_q, err_d;
    logic [7:0]    fifo_q [QDEPTH];
    logic [7:0]    fifo_d [QDEPTH];

    logic [2:0]    win_cnt_c;
    logic [16:0]   rom_left;
    logic          push_ok;
    logic          over_consume;
    logic [2:0]    push_cnt;
    logic [2:0]    retire_cnt;

    // Push needs room for a full word; the ROM tail may supply fewer than four bytes.
    always_comb begin
        win_cnt_c    = (level_q >= LW'(4)) ? 3'd4 : level_q[2:0];
        rom_left     = ROM_LIM - {1'b0, fetch_ptr_q};
        push_ok      = !redirect && (level_q <= LW'(QDEPTH - 4)) && ({1'b0, fetch_ptr_q} < ROM_LIM);
        over_consume = !redirect && ({1'b0, consume} > win_cnt_c);
        push_cnt     = 3'd0;
        if (push_ok) begin
            push_cnt = (rom_left >= 17'd4) ? 3'd4 : rom_left[2:0];
        end
        retire_cnt = 3'd0;
        if (!redirect) begin
            retire_cnt = over_consume ? win_cnt_c : {1'b0, consume};
        end
    end

    always_comb begin
        fifo_d      = fifo_q;
        fetch_ptr_d = fetch_ptr_q + {13'd0, push_cnt};
        wr_ptr_d    = wr_ptr_q + PW'(push_cnt);
        rd_ptr_d    = rd_ptr_q + PW'(retire_cnt);
        win_pc_d    = win_pc_q + {13'd0, retire_cnt};
        level_d     = level_q + LW'(push_cnt) - LW'(retire_cnt);
        err_d       = err_q | over_consume;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < push_cnt) begin
                fifo_d[wr_ptr_q + PW'(i)] = cxrom_data_in[8*i +: 8];
            end
        end
        if (redirect) begin
            fetch_ptr_d = redirect_pc;
            win_pc_d    = redirect_pc;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_ptr_q <= 16'h0000;
            win_pc_q    <= 16'h0000;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            fetch_ptr_q <= fetch_ptr_d;
            win_pc_q    <= win_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset; the level counter alone decides which entries are valid.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_comb begin
        win_data = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < win_cnt_c) begin
                win_data[8*i +: 8] = fifo_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    assign cxrom_addr = fetch_ptr_q;
    assign win_cnt    = win_cnt_c;
    assign win_pc     = win_pc_q;
    assign err        = err_q;

endmodule

// File: tb/tb_oc8051_fetch_queue.sv
// Self-checking bench for oc8051_fetch_queue: a byte scoreboard of expected code
// bytes is filled as the ROM is fetched and drained as the core consumes.
module tb_oc8051_fetch_queue;

   localparam int QDEPTH   = 8;
   localparam int ROM_SIZE = 10000;

   logic        clk;
   logic        rst;
   logic [15:0] cxrom_addr;
   logic [31:0] cxrom_data_in;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [1:0]  consume;
   logic [31:0] win_data;
   logic [2:0]  win_cnt;
   logic [15:0] win_pc;
   logic        err;

   int errors = 0;
   int checks = 0;

   logic [7:0]  expQ [$];
   logic [15:0] mFp;
   logic [15:0] mPc;
   logic        mErr;

   oc8051_fetch_queue #(.QDEPTH(QDEPTH), .ROM_SIZE(ROM_SIZE)) dut (
      .clk          (clk),
      .rst          (rst),
      .cxrom_addr   (cxrom_addr),
      .cxrom_data_in(cxrom_data_in),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .consume      (consume),
      .win_data     (win_data),
      .win_cnt      (win_cnt),
      .win_pc       (win_pc),
      .err          (err)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational code ROM whose contents are mem[a] = a[7:0].
   always_comb begin
      cxrom_data_in = '0;
      for (int i = 0; i < 4; i++) begin
         cxrom_data_in[8*i +: 8] = 8'(cxrom_addr + 16'(i));
      end
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Compares every output against the scoreboard and model registers.
   task automatic compareAll(input string tag);
      logic [31:0] expWord;
      int          expCnt;
      expWord = '0;
      expCnt  = (expQ.size() > 4) ? 4 : expQ.size();
      for (int i = 0; i < expCnt; i++) expWord[8*i +: 8] = expQ[i];
      checkOutput({tag, "_addr"}, {16'd0, cxrom_addr}, {16'd0, mFp});
      checkOutput({tag, "_cnt"},  {29'd0, win_cnt}, 32'(expCnt));
      checkOutput({tag, "_data"}, win_data, expWord);
      checkOutput({tag, "_pc"},   {16'd0, win_pc}, {16'd0, mPc});
      checkOutput({tag, "_err"},  {31'd0, err}, {31'd0, mErr});
   endtask

   // Drives one cycle of inputs, advances the expected state, then checks after the edge.
   task automatic applyStimulus(input logic r, input logic rd, input logic [15:0] rpc,
                                input logic [1:0] cons, input string tag);
      int wc;
      int c;
      int n;
      rst         = r;
      redirect    = rd;
      redirect_pc = rpc;
      consume     = cons;
      if (r) begin
         expQ.delete();
         mFp  = 16'h0000;
         mPc  = 16'h0000;
         mErr = 1'b0;
      end else if (rd) begin
         expQ.delete();
         mFp = rpc;
         mPc = rpc;
      end else begin
         wc = (expQ.size() > 4) ? 4 : expQ.size();
         c  = (int'(cons) > wc) ? wc : int'(cons);
         if (int'(cons) > wc) mErr = 1'b1;
         n = 0;
         if (expQ.size() <= QDEPTH - 4 && int'(mFp) < ROM_SIZE) begin
            n = ROM_SIZE - int'(mFp);
            if (n > 4) n = 4;
         end
         for (int k = 0; k < c; k++) void'(expQ.pop_front());
         for (int k = 0; k < n; k++) expQ.push_back(8'(mFp + 16'(k)));
         mFp = mFp + 16'(n);
         mPc = mPc + 16'(c);
      end
      @(posedge clk);
      #1;
      compareAll(tag);
   endtask

   int          wcv;
   logic [1:0]  consRand;
   logic [15:0] pcRand;

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; consume = '0;
      mFp = '0; mPc = '0; mErr = 1'b0;

      applyStimulus(1, 0, 16'h0000, 2'd0, "rst0");
      applyStimulus(1, 1, 16'h0055, 2'd3, "rst1");
      checkOutput("rst_cnt_zero", {29'd0, win_cnt}, 32'd0);
      checkOutput("rst_data_zero", win_data, 32'h0000_0000);

      applyStimulus(0, 0, 16'h0000, 2'd0, "boot1");
      checkOutput("boot_data", win_data, 32'h0302_0100);
      checkOutput("boot_cnt", {29'd0, win_cnt}, 32'd4);
      applyStimulus(0, 0, 16'h0000, 2'd0, "fill");
      checkOutput("fill_addr", {16'd0, cxrom_addr}, 32'h0000_0008);
      applyStimulus(0, 0, 16'h0000, 2'd0, "full");
      checkOutput("full_addr_hold", {16'd0, cxrom_addr}, 32'h0000_0008);

      for (int i = 0; i < 12; i++) begin
         wcv = (expQ.size() > 4) ? 4 : expQ.size();
         applyStimulus(0, 0, 16'h0000, (wcv >= 3) ? 2'd3 : 2'(wcv), "stream");
      end

      applyStimulus(0, 0, 16'h0000, 2'd0, "refill0");
      applyStimulus(0, 0, 16'h0000, 2'd0, "refill1");
      applyStimulus(0, 1, 16'h0100, 2'd3, "redir");
      checkOutput("redir_cnt", {29'd0, win_cnt}, 32'd0);
      checkOutput("redir_addr", {16'd0, cxrom_addr}, 32'h0000_0100);
      applyStimulus(0, 0, 16'h0000, 2'd0, "redir_fill");
      checkOutput("redir_data", win_data, 32'h0302_0100);
      checkOutput("redir_pc", {16'd0, win_pc}, 32'h0000_0100);

      for (int i = 0; i < 40; i++) begin
         wcv      = (expQ.size() > 4) ? 4 : expQ.size();
         consRand = 2'($urandom_range(0, (wcv > 3) ? 3 : wcv));
         pcRand   = 16'($urandom_range(0, 16'h27FF));
         applyStimulus(0, ($urandom_range(0, 9) == 0), pcRand, consRand, "rand");
      end

      applyStimulus(0, 1, 16'h270E, 2'd0, "tail_redir");
      applyStimulus(0, 0, 16'h0000, 2'd0, "tail_push");
      checkOutput("tail_cnt", {29'd0, win_cnt}, 32'd2);
      checkOutput("tail_data", win_data, 32'h0000_0F0E);
      applyStimulus(0, 0, 16'h0000, 2'd0, "tail_hold");
      checkOutput("tail_addr", {16'd0, cxrom_addr}, 32'h0000_2710);
      applyStimulus(0, 0, 16'h0000, 2'd3, "overrun");
      checkOutput("overrun_pc", {16'd0, win_pc}, 32'h0000_2710);
      checkOutput("overrun_err", {31'd0, err}, 32'd1);
      applyStimulus(0, 1, 16'h0000, 2'd0, "sticky_redir");
      applyStimulus(0, 0, 16'h0000, 2'd0, "sticky_a");
      applyStimulus(0, 0, 16'h0000, 2'd2, "sticky_b");
      checkOutput("sticky_err", {31'd0, err}, 32'd1);

      applyStimulus(1, 1, 16'h1234, 2'd3, "midrst");
      checkOutput("midrst_addr", {16'd0, cxrom_addr}, 32'h0000_0000);
      checkOutput("midrst_err", {31'd0, err}, 32'd0);
      checkOutput("midrst_cnt", {29'd0, win_cnt}, 32'd0);
      applyStimulus(0, 0, 16'h0000, 2'd0, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
